asp_irq_csr_responder: RTL and testbench
========================================

Name: asp_irq_csr_responder

Overview:
- MMIO-side responder for ASP interrupt sources (DMA_0, kernel, DMA_1, spare line).
- Captures rising edges on the per-source IRQ lines into sticky pending bits and applies a mask.
- Raises one vectored interrupt request per pending source toward the host interrupt interface, using a req/ack handshake.
- Exposes status, mask, clear and a request counter as 64-bit AVMM CSRs behind the ASP MMIO64 window.

Parameters:
- NUM_IRQ, 4, number of interrupt source lines; bit i maps to vector i.
- ADDR_WIDTH, 18, AVMM byte-address width; matches the ASP MMIO64 window.
- DATA_WIDTH, 64, AVMM data width; fixed at 64.
- VEC_WIDTH, 2, width of the vector id; must satisfy 2**VEC_WIDTH >= NUM_IRQ.

Ports:
- clk  in  1  single block clock
- reset_n  in  1  asynchronous, active-low reset
- irq_in  in  NUM_IRQ  source interrupt lines, synchronous to clk
- avmm_address  in  ADDR_WIDTH  byte address; bits [5:3] select the CSR
- avmm_read  in  1  read command
- avmm_write  in  1  write command
- avmm_writedata  in  64  write data
- avmm_byteenable  in  8  byte enables
- avmm_waitrequest  out  1  always 0 (responder never stalls)
- avmm_readdata  out  64  read data
- avmm_readdatavalid  out  1  read response strobe
- irq_req  out  1  interrupt request to the host interface
- irq_vec  out  VEC_WIDTH  vector id; stable while irq_req=1
- irq_ack  in  1  host accepted the request

Behaviour:
- Reset: all outputs 0; pending=0; sent=0; mask=all ones (all sources masked); req_count=0; FSM=IDLE.
- Edge capture:
  - irq_d is irq_in registered; rise = irq_in & ~irq_d.
  - A rise sets pending[i] on the next cycle.
- CSR map (word index = address[5:3]):
  - 0 STATUS, RO: {32'(pending&~mask), 32'(pending)}.
  - 1 MASK, RW: low NUM_IRQ bits; byteenable honoured; 1 = masked.
  - 2 CLEAR, WO: writing 1 to bit i clears pending[i] and sent[i]; reads return 0.
  - 3 REQ_COUNT, RO: 32-bit count of accepted requests, saturating at 0xFFFF_FFFF, zero-extended to 64 bits.
  - 4 TSTAMP: see Optional Feature.
  - 5–7 and address bits above [5:3] are ignored; unmapped words read 0.
- Read timing:
  - Latency is exactly 1 cycle: readdatavalid pulses for one cycle after avmm_read.
  - readdata holds its last value otherwise.
  - Back-to-back reads are supported at 1 per cycle.
  - read and write are never asserted together; if they are, the write is performed and the read is still answered.
- Set/clear collision: a rise and a CLEAR of the same bit in the same cycle leaves pending=1 and sent=0, so the event is re-requested.
- Eligible set: elig = pending & ~mask & ~sent. The selected source is the lowest set index.
- FSM:
  - IDLE: if elig≠0, latch irq_vec=lowest index, go to REQ. irq_req=1 from the cycle after entering REQ's decision (registered).
  - REQ: irq_req=1, irq_vec held. On irq_ack: set sent[irq_vec], increment req_count, go to GAP.
  - REQ: if the source is cleared or masked before ack, the request is still held until ack (no withdrawal).
  - GAP: one cycle with irq_req=0, then return to IDLE.
  - irq_ack while irq_req=0 is ignored.
- Masking a pending, unsent bit suppresses its request. Unmasking it later issues the request.
- Asynchronous reset mid-handshake drops irq_req immediately; no counter update occurs.

Optional Feature:
- Macro: ASP_IRQ_TIMESTAMP_EN.
- Defined:
  - Adds a 64-bit free-running cycle counter that resets to 0 and wraps.
  - On each irq_ack accept, the counter value is latched into TSTAMP (word 4, RO).
- Undefined: word 4 reads 0 and no counter logic is built.

Test Plan:
- Reset, then read words 0–3 → STATUS=0, MASK=0xF, REQ_COUNT=0; readdatavalid exactly 1 cycle after each read; irq_req=0.
- Write MASK=0x0, pulse irq_in[1] → STATUS=0x0000_0002_0000_0002; irq_req=1 with irq_vec=1. Ack after 3 cycles → REQ_COUNT=1, irq_req=0, and no re-request while pending stays set.
- Rise irq_in[2] and irq_in[0] in the same cycle, ack each request → vectors issued in order 0 then 2, each followed by a 1-cycle gap; REQ_COUNT=2.
- Pending[3] with MASK=0x8 → no irq_req. Write MASK=0 → irq_req with vec=3. Write CLEAR=0x8 in the same cycle as a new irq_in[3] rise → pending[3] stays 1 and a new request is issued after ack.
- Assert reset_n=0 while irq_req=1 → irq_req drops asynchronously; after release, pending=0 and REQ_COUNT is unchanged from its pre-request value, i.e. 0 after reset.
- With ASP_IRQ_TIMESTAMP_EN: ack at cycle N after reset → TSTAMP=N. Without the macro → word 4 reads 0.

Source files
------------

// File: rtl/asp_irq_csr_responder_if.sv
// Bus bundle for asp_irq_csr_responder.
//   AVMM side : avmm_address/read/write/writedata/byteenable in,
//               avmm_waitrequest/readdata/readdatavalid out.
//   IRQ side  : irq_req/irq_vec out, irq_ack in.
// slave modport is the responder's view; master is the host/bench view.
interface asp_irq_csr_responder_if #(
  parameter int unsigned ADDR_WIDTH = 18,
  parameter int unsigned VEC_WIDTH  = 2
);
  logic [ADDR_WIDTH-1:0] avmm_address;
  logic                  avmm_read;
  logic                  avmm_write;
  logic [63:0]           avmm_writedata;
  logic [7:0]            avmm_byteenable;
  logic                  avmm_waitrequest;
  logic [63:0]           avmm_readdata;
  logic                  avmm_readdatavalid;
  logic                  irq_req;
  logic [VEC_WIDTH-1:0]  irq_vec;
  logic                  irq_ack;

  modport slave (
    input  avmm_address, avmm_read, avmm_write, avmm_writedata, avmm_byteenable,
    input  irq_ack,
    output avmm_waitrequest, avmm_readdata, avmm_readdatavalid,
    output irq_req, irq_vec
  );

  modport master (
    output avmm_address, avmm_read, avmm_write, avmm_writedata, avmm_byteenable,
    output irq_ack,
    input  avmm_waitrequest, avmm_readdata, avmm_readdatavalid,
    input  irq_req, irq_vec
  );
endinterface

// File: rtl/asp_irq_csr_responder.sv
// MMIO-side responder for ASP interrupt sources (DMA_0, kernel, DMA_1, spare).
// Rising edges on irq_in set sticky pending bits; unmasked, not-yet-sent
// sources are forwarded one at a time (lowest index first) as a vectored
// req/ack handshake. CSRs (word = address[5:3]):
//   0 STATUS (RO) {pending&~mask, pending}   1 MASK (RW, 1 = masked)
//   2 CLEAR  (WO, reads 0)                   3 REQ_COUNT (RO, saturating)
//   4 TSTAMP (RO, only with ASP_IRQ_TIMESTAMP_EN, else reads 0)
// Ports: clk, reset_n (async, active-low), irq_in[NUM_IRQ], bus (slave modport
// of asp_irq_csr_responder_if carrying the AVMM and IRQ handshake signals).
// Optional macro ASP_IRQ_TIMESTAMP_EN: free-running 64-bit cycle counter
// latched into TSTAMP on every accepted request.
module asp_irq_csr_responder #(
  parameter int unsigned NUM_IRQ    = 4,
  parameter int unsigned ADDR_WIDTH = 18,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned VEC_WIDTH  = 2
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_IRQ-1:0]        irq_in,
  asp_irq_csr_responder_if.slave    bus
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_GAP} state_e;

  state_e                 state_q;
  logic                   irq_req_q;
  logic [VEC_WIDTH-1:0]   irq_vec_q;
  logic [31:0]            req_count_q;
  logic [NUM_IRQ-1:0]     irq_prev_q;
  logic [NUM_IRQ-1:0]     pending_q, pending_d;
  logic [NUM_IRQ-1:0]     sent_q, sent_d;
  logic [NUM_IRQ-1:0]     mask_q, mask_d;
  logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
  logic                   rdv_q;

  logic [2:0]             word_sel;
  logic [NUM_IRQ-1:0]     rise, clr, elig, ack_set;
  logic [VEC_WIDTH-1:0]   sel_vec;
  logic                   sel_found;
  logic                   accept;

`ifdef ASP_IRQ_TIMESTAMP_EN
  logic [63:0]            ts_cnt_q;
  logic [63:0]            tstamp_q;
`endif

  assign word_sel = (ADDR_WIDTH >= 6) ? bus.avmm_address[5:3] : 3'd0;
  assign rise     = irq_in & ~irq_prev_q;
  assign elig     = pending_q & ~mask_q & ~sent_q;
  assign accept   = (state_q == S_REQ) && bus.irq_ack;
  assign ack_set  = accept ? (NUM_IRQ'(1) << irq_vec_q) : '0;

  // Lowest set index of the eligible set.
  always_comb begin
    sel_vec   = '0;
    sel_found = 1'b0;
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      if (elig[i] && !sel_found) begin
        sel_vec   = VEC_WIDTH'(i);
        sel_found = 1'b1;
      end
    end
  end

  always_comb begin
    mask_d = mask_q;
    clr    = '0;
    if (bus.avmm_write && word_sel == 3'd1) begin
      for (int unsigned i = 0; i < NUM_IRQ; i++) begin
        if (bus.avmm_byteenable[i/8]) mask_d[i] = bus.avmm_writedata[i];
      end
    end
    if (bus.avmm_write && word_sel == 3'd2) clr = bus.avmm_writedata[NUM_IRQ-1:0];
    // A same-cycle rise wins over CLEAR for pending, while sent is cleared,
    // so the new event is requested again.
    pending_d = (pending_q & ~clr) | rise;
    sent_d    = (sent_q | ack_set) & ~clr;
  end

  always_comb begin
    rdata_d = '0;
    case (word_sel)
      3'd0: rdata_d = DATA_WIDTH'({32'(pending_q & ~mask_q), 32'(pending_q)});
      3'd1: rdata_d = DATA_WIDTH'(mask_q);
      3'd3: rdata_d = DATA_WIDTH'(req_count_q);
`ifdef ASP_IRQ_TIMESTAMP_EN
      3'd4: rdata_d = DATA_WIDTH'(tstamp_q);
`endif
      default: rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_prev_q <= '0;
      pending_q  <= '0;
      sent_q     <= '0;
      mask_q     <= '1;
      rdata_q    <= '0;
      rdv_q      <= 1'b0;
    end else begin
      irq_prev_q <= irq_in;
      pending_q  <= pending_d;
      sent_q     <= sent_d;
      mask_q     <= mask_d;
      rdv_q      <= bus.avmm_read;
      if (bus.avmm_read) rdata_q <= rdata_d;
    end
  end

  // Request handshake; once raised, a request is held until acked even if
  // its source is cleared or masked meanwhile.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      irq_req_q   <= 1'b0;
      irq_vec_q   <= '0;
      req_count_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (|elig) begin
            irq_vec_q <= sel_vec;
            irq_req_q <= 1'b1;
            state_q   <= S_REQ;
          end
        end
        S_REQ: begin
          if (bus.irq_ack) begin
            irq_req_q <= 1'b0;
            state_q   <= S_GAP;
            if (req_count_q != '1) req_count_q <= req_count_q + 32'd1;
          end
        end
        S_GAP:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef ASP_IRQ_TIMESTAMP_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ts_cnt_q <= '0;
      tstamp_q <= '0;
    end else begin
      ts_cnt_q <= ts_cnt_q + 64'd1;
      if (accept) tstamp_q <= ts_cnt_q;
    end
  end
`endif

  assign bus.avmm_waitrequest   = 1'b0;
  assign bus.avmm_readdata      = rdata_q;
  assign bus.avmm_readdatavalid = rdv_q;
  assign bus.irq_req            = irq_req_q;
  assign bus.irq_vec            = irq_vec_q;

endmodule

// File: tb/tb_asp_irq_csr_responder.sv
// Self-checking bench for asp_irq_csr_responder: a transaction-level model of
// the CSR/IRQ behaviour is stepped on every clock and compared against the
// DUT each falling edge, plus literal expectations in the directed sequence.
module tb_asp_irq_csr_responder;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] irq_in;

  int n_checks = 0;
  int n_pass   = 0;

  asp_irq_csr_responder_if #(.ADDR_WIDTH(18), .VEC_WIDTH(2)) bus();

  asp_irq_csr_responder #(
    .NUM_IRQ(4), .ADDR_WIDTH(18), .DATA_WIDTH(64), .VEC_WIDTH(2)
  ) dut (
    .clk(clk), .reset_n(reset_n), .irq_in(irq_in), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [3:0]  pend, mask, sent, prev;
    logic        req, gap;
    logic [1:0]  vec;
    logic [31:0] count;
    logic [63:0] ts, cnt;
    logic        rdv;
    logic [63:0] rdata;
  } model_t;

  model_t m;

  function automatic model_t m_reset();
    model_t r;
    r.pend = '0; r.mask = 4'hF; r.sent = '0; r.prev = '0;
    r.req = 1'b0; r.gap = 1'b0; r.vec = '0; r.count = '0;
    r.ts = '0; r.cnt = '0; r.rdv = 1'b0; r.rdata = '0;
    return r;
  endfunction

  function automatic logic [63:0] m_csr(input model_t s, input logic [2:0] w);
    case (w)
      3'd0: return {28'd0, s.pend & ~s.mask, 28'd0, s.pend};
      3'd1: return {60'd0, s.mask};
      3'd3: return {32'd0, s.count};
`ifdef ASP_IRQ_TIMESTAMP_EN
      3'd4: return s.ts;
`endif
      default: return 64'd0;
    endcase
  endfunction

  function automatic model_t m_step(input model_t s);
    model_t     n;
    logic [3:0] rise, elig, clr;
    logic [2:0] w;
    n    = s;
    w    = bus.avmm_address[5:3];
    rise = irq_in & ~s.prev;
    elig = s.pend & ~s.mask & ~s.sent;
    clr  = '0;
    n.prev = irq_in;
    n.rdv  = bus.avmm_read;
    if (bus.avmm_read) n.rdata = m_csr(s, w);
    if (bus.avmm_write && w == 3'd1)
      for (int i = 0; i < 4; i++)
        if (bus.avmm_byteenable[i/8]) n.mask[i] = bus.avmm_writedata[i];
    if (bus.avmm_write && w == 3'd2) clr = bus.avmm_writedata[3:0];
    if (s.req && bus.irq_ack) begin
      n.sent[s.vec] = 1'b1;
      if (s.count != 32'hFFFF_FFFF) n.count = s.count + 32'd1;
      n.ts  = s.cnt;
      n.req = 1'b0;
      n.gap = 1'b1;
    end else if (s.gap) begin
      n.gap = 1'b0;
    end else if (!s.req && elig != 4'd0) begin
      n.req = 1'b1;
      for (int i = 3; i >= 0; i--) if (elig[i]) n.vec = 2'(i);
    end
    n.cnt  = s.cnt + 64'd1;
    n.pend = (s.pend & ~clr) | rise;
    n.sent = n.sent & ~clr;
    return n;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) m <= m_reset();
    else          m <= m_step(m);
  end

  always @(negedge clk) begin
    if (reset_n) begin
      check("irq_req", {63'd0, bus.irq_req}, {63'd0, m.req});
      if (m.req) check("irq_vec", {62'd0, bus.irq_vec}, {62'd0, m.vec});
      check("readdatavalid", {63'd0, bus.avmm_readdatavalid}, {63'd0, m.rdv});
      check("readdata", bus.avmm_readdata, m.rdata);
      check("waitrequest", {63'd0, bus.avmm_waitrequest}, 64'd0);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    irq_in = '0;
    bus.avmm_address = '0; bus.avmm_read = 1'b0; bus.avmm_write = 1'b0;
    bus.avmm_writedata = '0; bus.avmm_byteenable = 8'hFF; bus.irq_ack = 1'b0;
    repeat (2) cyc();
    reset_n = 1'b1;
  endtask

  function automatic logic [17:0] waddr(input logic [2:0] w);
    return {12'd0, w, 3'd0};
  endfunction

  task automatic csr_wr(input logic [17:0] a, input logic [63:0] d, input logic [7:0] be);
    bus.avmm_address = a; bus.avmm_writedata = d; bus.avmm_byteenable = be;
    bus.avmm_write = 1'b1;
    cyc();
    bus.avmm_write = 1'b0; bus.avmm_byteenable = 8'hFF;
  endtask

  task automatic csr_rd(input string name, input logic [17:0] a, input logic [63:0] exp);
    bus.avmm_address = a;
    bus.avmm_read = 1'b1;
    cyc();
    bus.avmm_read = 1'b0;
    check({name, "_valid"}, {63'd0, bus.avmm_readdatavalid}, 64'd1);
    check(name, bus.avmm_readdata, exp);
  endtask

  task automatic pulse(input logic [3:0] p);
    irq_in = irq_in | p;
    cyc();
    irq_in = irq_in & ~p;
  endtask

  task automatic wait_req(input string name, input logic [1:0] vec);
    int k = 0;
    while (!bus.irq_req && k < 20) begin
      cyc();
      k++;
    end
    check({name, "_seen"}, {63'd0, bus.irq_req}, 64'd1);
    if (bus.irq_req) check({name, "_vec"}, {62'd0, bus.irq_vec}, {62'd0, vec});
  endtask

  task automatic ack();
    bus.irq_ack = 1'b1;
    cyc();
    bus.irq_ack = 1'b0;
    check("req_drop_after_ack", {63'd0, bus.irq_req}, 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  initial begin
    // Reset state and CSR defaults.
    do_reset();
    check("rst_irq_req", {63'd0, bus.irq_req}, 64'd0);
    check("rst_rdv", {63'd0, bus.avmm_readdatavalid}, 64'd0);
    check("rst_rdata", bus.avmm_readdata, 64'd0);
    csr_rd("rst_status", waddr(3'd0), 64'd0);
    csr_rd("rst_mask",   waddr(3'd1), 64'hF);
    csr_rd("rst_clear",  waddr(3'd2), 64'd0);
    csr_rd("rst_count",  waddr(3'd3), 64'd0);
    cyc();
    check("rdv_one_cycle", {63'd0, bus.avmm_readdatavalid}, 64'd0);

    // Single source request, late ack, no re-request while pending.
    csr_wr(waddr(3'd1), 64'd0, 8'hFF);
    pulse(4'b0010);
    csr_rd("status_irq1", waddr(3'd0), 64'h0000_0002_0000_0002);
    wait_req("req_irq1", 2'd1);
    repeat (3) cyc();
    ack();
    for (int i = 0; i < 5; i++) begin
      check("no_rerequest", {63'd0, bus.irq_req}, 64'd0);
      cyc();
    end
    csr_rd("count_after_1", waddr(3'd3), 64'd1);

    // Two simultaneous rises: vector 0 before vector 2.
    do_reset();
    csr_wr(waddr(3'd1), 64'd0, 8'hFF);
    pulse(4'b0101);
    wait_req("req_first_v0", 2'd0);
    ack();
    cyc();
    check("gap_idle", {63'd0, bus.irq_req}, 64'd0);
    wait_req("req_second_v2", 2'd2);
    ack();
    csr_rd("count_after_2", waddr(3'd3), 64'd2);

    // Masked pending, unmask, then CLEAR/rise collision.
    do_reset();
    csr_wr(waddr(3'd1), 64'h8, 8'hFF);
    pulse(4'b1000);
    for (int i = 0; i < 4; i++) begin
      check("masked_no_req", {63'd0, bus.irq_req}, 64'd0);
      cyc();
    end
    csr_rd("status_masked", waddr(3'd0), 64'h0000_0000_0000_0008);
    csr_wr(waddr(3'd1), 64'd0, 8'hFF);
    wait_req("req_unmasked_v3", 2'd3);
    ack();
    repeat (3) cyc();
    check("sent_blocks_req", {63'd0, bus.irq_req}, 64'd0);
    irq_in = 4'b1000;
    csr_wr(waddr(3'd2), 64'h8, 8'hFF);
    irq_in = 4'b0000;
    csr_rd("status_collision", waddr(3'd0), 64'h0000_0008_0000_0008);
    wait_req("req_rerequest_v3", 2'd3);
    ack();
    csr_rd("count_collision", waddr(3'd3), 64'd2);

    // Byte enables, address aliasing, unmapped words.
    csr_wr(waddr(3'd1), 64'hF, 8'hFE);
    csr_rd("mask_be_off", waddr(3'd1), 64'd0);
    csr_wr(waddr(3'd1), 64'h5, 8'h01);
    csr_rd("mask_be_on", waddr(3'd1), 64'h5);
    csr_rd("mask_alias", 18'h3_0008, 64'h5);
    csr_rd("word5", waddr(3'd5), 64'd0);
    csr_rd("word6", waddr(3'd6), 64'd0);
    csr_rd("word7", waddr(3'd7), 64'd0);

    // Asynchronous reset while a request is outstanding.
    do_reset();
    csr_wr(waddr(3'd1), 64'd0, 8'hFF);
    pulse(4'b0001);
    wait_req("req_before_reset", 2'd0);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_drop", {63'd0, bus.irq_req}, 64'd0);
    cyc();
    reset_n = 1'b1;
    csr_rd("status_post_reset", waddr(3'd0), 64'd0);
    csr_rd("count_post_reset",  waddr(3'd3), 64'd0);
    csr_rd("mask_post_reset",   waddr(3'd1), 64'hF);

    // Timestamp word.
    do_reset();
    csr_wr(waddr(3'd1), 64'd0, 8'hFF);
    pulse(4'b0100);
    wait_req("req_tstamp", 2'd2);
    ack();
`ifdef ASP_IRQ_TIMESTAMP_EN
    csr_rd("tstamp", waddr(3'd4), m.ts);
`else
    csr_rd("tstamp_absent", waddr(3'd4), 64'd0);
`endif
    repeat (2) cyc();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
